// File: rtl/prio_intr_ctrl.sv
// rtl/prio_intr_ctrl.sv - N-channel prioritised interrupt controller with claim/complete
// Optional 2-flop input synchronizer: define PRIO_INTR_CTRL_SYNC_EN.

package core_v_mcu_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;
endpackage

module prio_intr_ctrl #(
   parameter int unsigned NumChannels = 16,
   parameter type reg_req_t = core_v_mcu_pkg::reg_req_t,
   parameter type reg_rsp_t = core_v_mcu_pkg::reg_rsp_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  reg_req_t               reg_req_i,
   output reg_rsp_t               reg_rsp_o,
   input  logic [NumChannels-1:0] intr_i,
   output logic                   irq_o,
   output logic [5:0]             irq_id_o
);

   localparam logic [2:0] OFF_PENDING   = 3'd0;
   localparam logic [2:0] OFF_ENABLE    = 3'd1;
   localparam logic [2:0] OFF_MODE      = 3'd2;
   localparam logic [2:0] OFF_CLAIM     = 3'd3;
   localparam logic [2:0] OFF_INSERVICE = 3'd4;

   logic [NumChannels-1:0] pending_q;
   logic [NumChannels-1:0] enable_q;
   logic [NumChannels-1:0] mode_q;
   logic [NumChannels-1:0] inservice_q;
   logic [NumChannels-1:0] intr_s;
   logic [NumChannels-1:0] intr_q;
   logic [NumChannels-1:0] intr_qq;
   logic [NumChannels-1:0] rise;
   logic [NumChannels-1:0] deliverable;
   logic [NumChannels-1:0] winner_onehot;
   logic [NumChannels-1:0] w1c_mask;
   logic [NumChannels-1:0] claim_mask;
   logic [NumChannels-1:0] complete_mask;
   logic [NumChannels-1:0] pending_d;
   logic [NumChannels-1:0] inservice_d;
   logic [5:0]             winner_id;
   logic [2:0]             off;
   logic                   addr_ok;
   logic                   rd_acc;
   logic                   wr_acc;
   logic                   unused_bits;

`ifdef PRIO_INTR_CTRL_SYNC_EN
   logic [NumChannels-1:0] sync_q1;
   logic [NumChannels-1:0] sync_q2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= intr_i;
         sync_q2 <= sync_q1;
      end
   end

   assign intr_s = sync_q2;
`else
   assign intr_s = intr_i;
`endif

   // Byte lane strobes and the sub-word address bits have no meaning here.
   assign unused_bits = ^{reg_req_i.wstrb, reg_req_i.addr[1:0], reg_req_i.wdata};

   assign off     = reg_req_i.addr[4:2];
   assign addr_ok = (reg_req_i.addr[31:5] == '0) && (off <= OFF_INSERVICE);
   assign rd_acc  = reg_req_i.valid && !reg_req_i.write && addr_ok;
   assign wr_acc  = reg_req_i.valid &&  reg_req_i.write && addr_ok;

   assign deliverable = pending_q & enable_q & ~inservice_q;
   assign irq_o       = |deliverable;
   assign irq_id_o    = winner_id;

   // Scan downwards so the lowest deliverable index is the last one kept.
   always_comb begin
      winner_id     = '0;
      winner_onehot = '0;
      for (int i = NumChannels - 1; i >= 0; i--) begin
         if (deliverable[i]) begin
            winner_id        = 6'(i + 1);
            winner_onehot    = '0;
            winner_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.ready = 1'b1;
      if (!rst_i && reg_req_i.valid) begin
         if (!addr_ok) begin
            reg_rsp_o.error = 1'b1;
         end else if (!reg_req_i.write) begin
            case (off)
               OFF_PENDING:   reg_rsp_o.rdata[NumChannels-1:0] = pending_q;
               OFF_ENABLE:    reg_rsp_o.rdata[NumChannels-1:0] = enable_q;
               OFF_MODE:      reg_rsp_o.rdata[NumChannels-1:0] = mode_q;
               OFF_CLAIM:     reg_rsp_o.rdata[5:0]             = winner_id;
               OFF_INSERVICE: reg_rsp_o.rdata[NumChannels-1:0] = inservice_q;
               default:       reg_rsp_o.rdata                  = '0;
            endcase
         end
      end
   end

   always_comb begin
      w1c_mask      = '0;
      claim_mask    = '0;
      complete_mask = '0;
      if (wr_acc && off == OFF_PENDING) begin
         w1c_mask = reg_req_i.wdata[NumChannels-1:0] & mode_q;
      end
      if (rd_acc && off == OFF_CLAIM) begin
         claim_mask = winner_onehot;
      end
      if (wr_acc && off == OFF_CLAIM) begin
         for (int i = 0; i < NumChannels; i++) begin
            if (reg_req_i.wdata == 32'(i + 1)) begin
               complete_mask[i] = inservice_q[i];
            end
         end
      end
   end

   // A fresh edge beats any clear arriving in the same cycle.
   assign rise        = intr_q & ~intr_qq;
   assign pending_d   = (mode_q & ((pending_q | rise) & ~((w1c_mask | claim_mask) & ~rise)))
                      | (~mode_q & intr_s);
   assign inservice_d = (inservice_q | claim_mask) & ~complete_mask;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q   <= '0;
         enable_q    <= '0;
         mode_q      <= '0;
         inservice_q <= '0;
         intr_q      <= '0;
         intr_qq     <= '0;
      end else begin
         intr_q      <= intr_s;
         intr_qq     <= intr_q;
         pending_q   <= pending_d;
         inservice_q <= inservice_d;
         if (wr_acc && off == OFF_ENABLE) begin
            enable_q <= reg_req_i.wdata[NumChannels-1:0];
         end
         if (wr_acc && off == OFF_MODE) begin
            mode_q <= reg_req_i.wdata[NumChannels-1:0];
         end
      end
   end

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// tb/tb_prio_intr_ctrl.sv - scoreboard bench for prio_intr_ctrl against a channel-level reference model
module tb_prio_intr_ctrl;
   import core_v_mcu_pkg::*;

   localparam int N = 16;
`ifdef PRIO_INTR_CTRL_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   localparam logic [31:0] A_PEND = 32'h00;
   localparam logic [31:0] A_EN   = 32'h04;
   localparam logic [31:0] A_MODE = 32'h08;
   localparam logic [31:0] A_CLM  = 32'h0C;
   localparam logic [31:0] A_ISV  = 32'h10;

   logic           clk = 1'b0;
   logic           rst;
   reg_req_t       req;
   reg_rsp_t       rsp;
   logic [N-1:0]   intr;
   logic           irq;
   logic [5:0]     irq_id;
   logic [N-1:0]   cur_in;

   always #5 clk = ~clk;

   prio_intr_ctrl #(.NumChannels(N)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .reg_req_i(req),
      .reg_rsp_o(rsp),
      .intr_i   (intr),
      .irq_o    (irq),
      .irq_id_o (irq_id)
   );

   typedef struct {
      bit          acc;
      bit          rd;
      logic [31:0] rdata;
      bit          err;
      bit          irq;
      logic [5:0]  id;
      int          plan_val;
      int          plan_id;
      string       tag;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   bit [N-1:0] m_pend, m_en, m_mode, m_isv;
   bit [N-1:0] seen[$];

   function automatic int m_winner();
      for (int i = 0; i < N; i++) begin
         if (m_pend[i] && m_en[i] && !m_isv[i]) return i;
      end
      return -1;
   endfunction

   function automatic void m_read(input logic [31:0] a, output logic [31:0] d, output bit e);
      d = '0;
      e = 1'b0;
      case (a & ~32'h3)
         A_PEND:  d = 32'(m_pend);
         A_EN:    d = 32'(m_en);
         A_MODE:  d = 32'(m_mode);
         A_CLM:   d = 32'(m_winner() + 1);
         A_ISV:   d = 32'(m_isv);
         default: e = 1'b1;
      endcase
   endfunction

   // One clock edge of the controller, channel by channel.
   function automatic void m_step(input bit r, input bit v, input bit wr, input logic [31:0] a,
                                  input logic [31:0] wd, input bit [N-1:0] in);
      int w;
      bit [N-1:0] q_new, q_old, qq_old, pend_n, isv_n;
      bit ok, rise, claimed, cleared;
      logic [31:0] wa;
      if (r) begin
         m_pend = '0;
         m_en   = '0;
         m_mode = '0;
         m_isv  = '0;
         seen.delete();
         for (int k = 0; k < S + 3; k++) seen.push_back('0);
         return;
      end
      w  = m_winner();
      wa = a & ~32'h3;
      ok = v && (wa inside {A_PEND, A_EN, A_MODE, A_CLM, A_ISV});
      seen.push_back(in);
      void'(seen.pop_front());
      q_new  = seen[2];
      q_old  = seen[1];
      qq_old = seen[0];
      pend_n = m_pend;
      isv_n  = m_isv;
      for (int i = 0; i < N; i++) begin
         rise    = q_old[i] && !qq_old[i];
         claimed = ok && !wr && wa == A_CLM && w == i;
         cleared = claimed || (ok && wr && wa == A_PEND && wd[i]);
         if (claimed) isv_n[i] = 1'b1;
         if (ok && wr && wa == A_CLM && wd == 32'(i + 1) && m_isv[i]) isv_n[i] = 1'b0;
         if (m_mode[i]) pend_n[i] = rise ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
         else           pend_n[i] = q_new[i];
      end
      m_pend = pend_n;
      m_isv  = isv_n;
      if (ok && wr && wa == A_EN)   m_en   = wd[N-1:0];
      if (ok && wr && wa == A_MODE) m_mode = wd[N-1:0];
   endfunction

   task automatic step(input bit r, input bit v, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int pv, input int pid, input string tag);
      exp_t e;
      int   w;
      rst       = r;
      req.valid = v;
      req.write = wr;
      req.addr  = a;
      req.wdata = wd;
      req.wstrb = 4'($urandom);
      intr      = cur_in;
      w         = m_winner();
      e.acc     = v;
      e.rd      = v && !wr;
      e.rdata   = '0;
      e.err     = 1'b0;
      if (v && !r) begin
         m_read(a, e.rdata, e.err);
         if (wr) e.rdata = '0;
      end
      e.irq      = (w >= 0);
      e.id       = 6'(w + 1);
      e.plan_val = pv;
      e.plan_id  = pid;
      e.tag      = tag;
      sbq.push_back(e);
      @(posedge clk);
      m_step(r, v, wr, a, wd, cur_in);
      #1;
   endtask

   task automatic idle(input int pid, input string tag);
      step(1'b0, 1'b0, 1'b0, '0, '0, -1, pid, tag);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, 1'b1, a, d, -1, -1, "wr");
   endtask

   task automatic rd(input logic [31:0] a, input int pv, input int pid, input string tag);
      step(1'b0, 1'b1, 1'b0, a, '0, pv, pid, tag);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.tag, ".ready"}, 32'(rsp.ready), 32'd1);
            chk({e.tag, ".irq"}, 32'(irq), 32'(e.irq));
            chk({e.tag, ".irq_id"}, 32'(irq_id), 32'(e.id));
            if (e.acc) chk({e.tag, ".error"}, 32'(rsp.error), 32'(e.err));
            if (e.rd)  chk({e.tag, ".rdata"}, rsp.rdata, e.rdata);
            if (e.plan_val >= 0) chk({e.tag, ".plan_rdata"}, rsp.rdata, 32'(e.plan_val));
            if (e.plan_id >= 0)  chk({e.tag, ".plan_id"}, 32'(irq_id), 32'(e.plan_id));
         end
      end
   end

   initial begin : driver
      logic [31:0] a, d;
      bit          w;
      rst    = 1'b1;
      req    = '0;
      cur_in = '1;
      intr   = cur_in;
      m_step(1'b1, 1'b0, 1'b0, '0, '0, '0);
      @(posedge clk);
      @(posedge clk);
      #1;

      // reset held with every source asserted
      step(1'b1, 1'b1, 1'b0, A_PEND, '0, 0, 0, "rst_pend");
      step(1'b1, 1'b1, 1'b0, A_EN,   '0, 0, 0, "rst_en");
      step(1'b1, 1'b1, 1'b0, A_MODE, '0, 0, 0, "rst_mode");
      step(1'b1, 1'b1, 1'b0, A_CLM,  '0, 0, 0, "rst_claim");
      step(1'b1, 1'b1, 1'b0, A_ISV,  '0, 0, 0, "rst_isv");
      cur_in = '0;
      step(1'b0, 1'b0, 1'b0, '0, '0, -1, 0, "rst_release");
      rd(A_PEND, 0, 0, "post_rst_pend");

      // edge delivery with simultaneous pulses on 4 and 5
      wr(A_MODE, 32'hFFFF);
      wr(A_EN, 32'h0030);
      cur_in = 16'h0030;
      idle(0, "edge_pulse");
      cur_in = '0;
      for (int k = 0; k <= S; k++) idle(0, "edge_wait");
      idle(5, "edge_rise");
      rd(A_CLM, 5, 5, "edge_claim5");
      rd(A_CLM, 6, 6, "edge_claim6");
      rd(A_ISV, 32'h30, 0, "edge_isv");
      wr(A_CLM, 32'd5);
      wr(A_CLM, 32'd6);
      rd(A_ISV, 0, -1, "edge_done");

      // complete re-exposes a still-high level source
      wr(A_MODE, 32'h0);
      wr(A_EN, 32'h1);
      cur_in = 16'h0001;
      for (int k = 0; k < S + 2; k++) idle(-1, "lvl_wait");
      rd(A_CLM, 1, 1, "lvl_claim");
      idle(0, "lvl_masked");
      wr(A_CLM, 32'd1);
      idle(1, "lvl_reexposed");
      cur_in = '0;
      idle(1, "lvl_drop");
      for (int k = 0; k < S; k++) idle(-1, "lvl_drop_wait");
      idle(0, "lvl_gone");

      // W1C on channel 2 racing a fresh edge
      wr(A_MODE, 32'h4);
      wr(A_EN, 32'h4);
      cur_in = 16'h0004;
      idle(-1, "w1c_pulse");
      cur_in = '0;
      for (int k = 0; k < S; k++) idle(-1, "w1c_wait");
      wr(A_PEND, 32'h4);
      rd(A_PEND, 4, 3, "w1c_race");
      wr(A_PEND, 32'h4);
      rd(A_PEND, 0, 0, "w1c_plain");

      // protocol errors and ignored completes
      rd(32'h14, 0, -1, "bad_offset");
      cur_in = 16'h0004;
      idle(-1, "err_pulse");
      cur_in = '0;
      for (int k = 0; k <= S; k++) idle(-1, "err_wait");
      rd(A_CLM, 3, 3, "err_claim");
      wr(A_CLM, 32'd33);
      rd(A_ISV, 4, 0, "err_cmp33");
      wr(A_CLM, 32'd1);
      rd(A_ISV, 4, 0, "err_cmp_notisv");
      wr(A_CLM, 32'd0);
      rd(A_ISV, 4, 0, "err_cmp0");
      wr(A_CLM, 32'd3);
      rd(A_ISV, 0, 0, "err_cmp3");
      rd(A_CLM, 0, 0, "empty_claim");
      rd(A_ISV, 0, 0, "empty_claim_isv");

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) cur_in[b] = ~cur_in[b];
         case ($urandom_range(0, 7))
            0: a = A_PEND;
            1: a = A_EN;
            2: a = A_MODE;
            3, 4: a = A_CLM;
            5: a = A_ISV;
            6: a = 32'h14;
            default: a = $urandom;
         endcase
         if (a <= A_ISV) a = a | 32'($urandom_range(0, 3));
         w = ($urandom_range(0, 2) == 0);
         d = ((a & ~32'h3) == A_CLM) ? 32'($urandom_range(0, 34)) : $urandom;
         if ($urandom_range(0, 199) == 0)
            step(1'b1, 1'b1, 1'b0, a, d, -1, -1, "rnd_rst");
         else if ($urandom_range(0, 3) == 0)
            idle(-1, "rnd_idle");
         else
            step(1'b0, 1'b1, w, a, d, -1, -1, "rnd_acc");
      end

      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
